// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding word bus master with alignment checks and load extension.
// Optional macro LSU_TIMEOUT_EN adds a bus watchdog bounded by TIMEOUT_CYCLES.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  ls_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_range
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    function automatic logic is_legal(input logic is_store, input logic [2:0] t, input logic [1:0] a);
        logic ok;
        case (t[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~a[0];
            2'b10:   ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        if ((is_store && t[2]) || (!is_store && (t == 3'b110))) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
        case (t[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] t, input logic [31:0] w);
        case (t[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend per ls_type[2].
    function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {a, 3'b000};
        case (t[1:0])
            2'b00:   return t[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return t[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misaligned_q, misaligned_d;
    logic        timeout_q, timeout_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  ls_type_q, ls_type_d;
    logic [1:0]  offset_q, offset_d;
`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

    // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        misaligned_d = misaligned_q;
        timeout_d    = timeout_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        ls_type_d    = ls_type_q;
        offset_d     = offset_q;
`ifdef LSU_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && (mem_read || mem_write)) begin
                    if (is_legal(mem_write, ls_type, addr[1:0])) begin
                        state_d     = ST_ACCESS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = byte_en(ls_type, addr[1:0]);
                        bus_wdata_d = mem_write ? lane_wdata(ls_type, wdata) : 32'd0;
                        ls_type_d   = ls_type;
                        offset_d    = addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        wait_cnt_d  = 16'd0;
`endif
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        misaligned_d = 1'b1;
                        rdata_d      = 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus_ack) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = bus_we_q ? 32'd0 : load_extend(ls_type_q, offset_q, bus_rdata);
                    bus_req_d    = 1'b0;
                    bus_we_d     = 1'b0;
                    bus_be_d     = 4'd0;
                    bus_wdata_d  = 32'd0;
                    bus_addr_d   = 32'd0;
`ifdef LSU_TIMEOUT_EN
                end else if (wait_cnt_q + 16'd1 >= TIMEOUT_LIMIT) begin
                    // Limit reached this cycle with no ack: abandon the access.
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    timeout_d    = 1'b1;
                    rdata_d      = 32'd0;
                    bus_req_d    = 1'b0;
                    bus_we_d     = 1'b0;
                    bus_be_d     = 4'd0;
                    bus_wdata_d  = 32'd0;
                    bus_addr_d   = 32'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
`else
                end else begin
                    state_d = ST_ACCESS;
`endif
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                misaligned_d = 1'b0;
                timeout_d    = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                misaligned_d = 1'b0;
                timeout_d    = 1'b0;
                bus_req_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset aborts any access without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_be_q     <= 4'd0;
            bus_wdata_q  <= 32'd0;
            ls_type_q    <= 3'd0;
            offset_q     <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            ls_type_q    <= ls_type_d;
            offset_q     <= offset_d;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign misaligned = misaligned_q;
    assign timeout    = timeout_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: table of requests plus timeout and reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, mem_write, mem_read;
    logic [2:0]  ls_type;
    logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic        resp_valid, misaligned, timeout, bus_req, bus_we, bus_ack;
    logic [3:0]  bus_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
    load_store_unit dut (
`endif
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_write(mem_write), .mem_read(mem_read), .ls_type(ls_type), .addr(addr),
        .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata), .misaligned(misaligned),
        .timeout(timeout), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        mw;
        logic        mr;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] brd;
        int          dly;
        logic        legal;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic mw, input logic mr, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; mem_write = mw; mem_read = mr; ls_type = t; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        ls_type = 3'b000; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    endtask

    task automatic run_vec(input vec_t v);
        drive_req(v.mw, v.mr, v.t, v.a, v.wd);
        if (v.legal) begin
            for (int c = 0; c <= v.dly; c++) begin
                chk("bus_req", {31'd0, bus_req}, 32'd1);
                chk("bus_we", {31'd0, bus_we}, {31'd0, v.mw});
                chk("bus_addr", bus_addr, {v.a[31:2], 2'b00});
                chk("bus_be", {28'd0, bus_be}, {28'd0, v.be});
                chk("bus_wdata", bus_wdata, v.bwd);
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                chk("resp_early", {31'd0, resp_valid}, 32'd0);
                if (c == v.dly) begin
                    bus_ack = 1'b1; bus_rdata = v.brd;
                end else begin
                    bus_rdata = 32'hA5A5_A5A5;
                end
                @(negedge clk);
            end
            bus_ack = 1'b0; bus_rdata = 32'h0BAD_F00D;
            chk("resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("misaligned_ok", {31'd0, misaligned}, 32'd0);
            chk("bus_req_drop", {31'd0, bus_req}, 32'd0);
        end else begin
            chk("no_bus_req", {31'd0, bus_req}, 32'd0);
            chk("resp_valid_err", {31'd0, resp_valid}, 32'd1);
            chk("misaligned_err", {31'd0, misaligned}, 32'd1);
        end
        chk("timeout_clr", {31'd0, timeout}, 32'd0);
        chk("rdata", rdata, v.rd);
        @(negedge clk);
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
        chk("misaligned_clr", {31'd0, misaligned}, 32'd0);
        chk("rdata_hold", rdata, v.rd);
    endtask

    function automatic vec_t mk(input logic mw, input logic mr, input logic [2:0] t,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                                input int dly, input logic legal, input logic [3:0] be,
                                input logic [31:0] bwd, input logic [31:0] rd);
        vec_t v;
        v.mw = mw; v.mr = mr; v.t = t; v.a = a; v.wd = wd; v.brd = brd; v.dly = dly;
        v.legal = legal; v.be = be; v.bwd = bwd; v.rd = rd;
        return v;
    endfunction

    initial begin
        //             mw    mr    type    addr          wdata         bus_rdata   dly legal be       bus_wdata     rdata
        vecs[0]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 1'b1, 4'b1000, 32'h0,        32'hFFFF_FF80);
        vecs[1]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_0010, 32'h1234_5678, 32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0);
        vecs[4]  = mk(1'b0, 1'b1, 3'b101, 32'h0000_4002, 32'h0,        32'h9ABC_0000, 5, 1'b1, 4'b1100, 32'h0,        32'h0000_9ABC);
        vecs[5]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h1234_5678, 32'h0,        1, 1'b1, 4'b1111, 32'h1234_5678, 32'h0);
        vecs[6]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_6000, 32'h0,        32'h0000_8001, 0, 1'b1, 4'b0011, 32'h0,        32'hFFFF_8001);
        vecs[7]  = mk(1'b0, 1'b1, 3'b100, 32'h0000_7001, 32'h0,        32'h0000_AB00, 2, 1'b1, 4'b0010, 32'h0,        32'h0000_00AB);
        vecs[8]  = mk(1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0);
        vecs[10] = mk(1'b1, 1'b1, 3'b000, 32'h0000_8001, 32'h0000_00A5, 32'h0,        0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        vecs[11] = mk(1'b1, 1'b0, 3'b001, 32'h0000_9001, 32'hFFFF_FFFF, 32'h0,        0, 1'b0, 4'b0000, 32'h0,        32'h0);
        vecs[12] = mk(1'b0, 1'b1, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 1'b1, 4'b0001, 32'h0,        32'h0000_007F);

        rst_n = 1'b0; req_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        ls_type = 3'b000; addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // Request with neither read nor write, and a stray ack in IDLE: both ignored.
        @(negedge clk);
        req_valid = 1'b1; mem_write = 1'b0; mem_read = 1'b0; addr = 32'h0000_0003; ls_type = 3'b010;
        bus_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("ignore_ready", {31'd0, req_ready}, 32'd1);
            chk("ignore_bus_req", {31'd0, bus_req}, 32'd0);
            chk("ignore_resp", {31'd0, resp_valid}, 32'd0);
        end
        req_valid = 1'b0; bus_ack = 1'b0;

        // Access that is never acknowledged.
        drive_req(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0);
`ifdef LSU_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            chk("to_bus_req_high", {31'd0, bus_req}, 32'd1);
            chk("to_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("to_bus_req_drop", {31'd0, bus_req}, 32'd0);
        chk("to_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("to_timeout", {31'd0, timeout}, 32'd1);
        chk("to_rdata", rdata, 32'd0);
        @(negedge clk);
        chk("to_timeout_clr", {31'd0, timeout}, 32'd0);
        drive_req(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0);
`else
        for (int c = 0; c < 20; c++) begin
            chk("hang_bus_req", {31'd0, bus_req}, 32'd1);
            chk("hang_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
`endif
        // Async reset in the middle of an access.
        chk("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_bus_req", {31'd0, bus_req}, 32'd0);
        chk("async_ready", {31'd0, req_ready}, 32'd1);
        chk("async_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_resp", {31'd0, resp_valid}, 32'd0);
            chk("post_rst_bus_req", {31'd0, bus_req}, 32'd0);
        end
        run_vec(mk(1'b1, 1'b0, 3'b010, 32'h0000_A004, 32'hCAFE_F00D, 32'h0, 0, 1'b1,
                   4'b1111, 32'hCAFE_F00D, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side consumer of the decoder's MemWrite / MemtoReg / LoadOrStoreTYPE outputs.
- Accepts one load or store request per handshake.
- Checks alignment and funct3 legality.
- Drives a single-outstanding word-addressed data bus with byte enables.
- Returns extended load data, or an error flag, to the writeback stage.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles bus_req may stay high without bus_ack (LSU_TIMEOUT_EN only); range 1..65535.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept (high only in IDLE)
- mem_write  in  1  store (decoder MemWrite)
- mem_read  in  1  load (decoder MemtoReg)
- ls_type  in  3  funct3 (decoder LoadOrStoreTYPE)
- addr  in  32  effective byte address (ALU result)
- wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  32  extended load data (0 for stores/errors)
- misaligned  out  1  with resp_valid: misaligned or illegal ls_type
- timeout  out  1  with resp_valid: bus timeout
- bus_req  out  1  bus access active
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  access complete; bus_rdata valid same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset: clock clk; reset rst_n is asynchronous and active-low.
  - Asserting rst_n low forces state IDLE immediately.
  - All registered outputs go to 0: resp_valid, rdata, misaligned, timeout, bus_req, bus_we, bus_addr, bus_be, bus_wdata.
  - req_ready is decoded from state and is 1 in IDLE, 0 elsewhere.
  - Reset mid-access drops bus_req at once; no response is ever issued for the aborted request.
- States:
  - IDLE: waits for a request.
  - ACCESS: bus_req held high.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Acceptance: request accepted in IDLE when req_valid & (mem_read | mem_write).
  - req_valid with both low is ignored: stay IDLE, no response.
  - If both are high, the request is treated as a store.
- Legality check, from ls_type[1:0] and addr[1:0]:
  - Byte (00): always legal.
  - Half (01): requires addr[0] = 0.
  - Word (10): requires addr[1:0] = 00.
  - ls_type[1:0] = 11: illegal.
  - Store with ls_type[2] = 1: illegal.
  - Load with ls_type = 110: illegal (RV32).
- Illegal request: IDLE -> RESP. No bus activity; misaligned = 1, rdata = 0. resp_valid is asserted the cycle after acceptance.
- Legal request: IDLE -> ACCESS. In that edge, register bus_req = 1, bus_we, bus_addr, bus_be and bus_wdata; these stay stable until ack.
  - Byte: bus_be = 0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - Half: bus_be = 0011 << addr[1:0]; bus_wdata = {2{wdata[15:0]}}.
  - Word: bus_be = 1111; bus_wdata = wdata.
  - Loads drive the same bus_be; bus_wdata = 0.
- ACCESS with bus_ack = 1 -> RESP.
  - bus_req drops in the same edge.
  - For loads, rdata captures the lane selected by addr[1:0].
  - ls_type[2] = 0 sign-extends; ls_type[2] = 1 zero-extends.
- Latency:
  - Accept at edge N; bus_req high from N.
  - Ack sampled at edge M; resp_valid high during cycle M..M+1.
  - Zero-wait ack gives resp_valid two cycles after acceptance.
- bus_ack outside ACCESS is ignored.
- resp_valid, misaligned and timeout clear on leaving RESP.
- rdata holds its value until the next response.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack, go to RESP with timeout = 1, rdata = 0, bus_req dropped.
  - Ack in the same cycle as the limit wins; this is a normal completion.
- Not defined: no counter; timeout is tied to 0; ACCESS waits indefinitely.

Test Plan:
- lb, ls_type = 000, addr = 0x1003, bus_rdata = 0x80FF_1234, ack on first ACCESS cycle -> bus_addr = 0x1000, bus_be = 1000; rdata = 0xFFFF_FF80 two cycles after acceptance.
- sh, ls_type = 001, addr = 0x2002, wdata = 0xDEAD_BEEF -> bus_we = 1, bus_be = 1100, bus_wdata = 0xBEEF_BEEF; resp_valid with misaligned = 0.
- lw, addr = 0x3001 -> no bus_req; resp_valid the next cycle with misaligned = 1, rdata = 0. Also sb with ls_type = 100 -> misaligned = 1.
- lhu, addr = 0x4002, bus_ack delayed 5 cycles, bus_rdata = 0x9ABC_0000 -> bus signals stable 6 cycles, req_ready = 0 throughout; rdata = 0x0000_9ABC.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES = 4, no ack -> bus_req high exactly 4 cycles; resp_valid with timeout = 1. Without the macro: no response, bus_req stays high.
- Assert rst_n low mid-ACCESS -> bus_req = 0 asynchronously, no resp_valid. After release, req_ready = 1 and a new sw completes normally.
